// File: rtl/ai_qram_pkg.sv
// Shared sizing constants and helpers for the three-requester QRAM read arbiter.
package ai_qram_pkg;

   localparam int N_REQ     = 3;
   localparam int TAG_DEPTH = 4;
   localparam int ID_W      = 2;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 64;
   localparam int PTR_W     = 2;
   localparam int CNT_W     = 3;

   typedef logic [ID_W-1:0]   id_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   // Next round-robin position after requester k, modulo N_REQ.
   function automatic id_t rr_next(input id_t k);
      return (k == id_t'(N_REQ - 1)) ? id_t'(0) : id_t'(k + 1'b1);
   endfunction

endpackage

// File: rtl/ai_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per read command still awaiting data.
module ai_tag_fifo
   import ai_qram_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  id_t              din,
   output id_t              dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   id_t              mem [TAG_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(TAG_DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // 2-bit pointers wrap 3 -> 0 on their own.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // NOTE: storage has no reset; count and pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok && !clear) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ai_qram_arb.sv
// Round-robin arbiter for three QRAM read requesters, with in-order tag tracking and response routing.
module ai_qram_arb
   import ai_qram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic              r0_valid,
   output logic              r0_ready,
   output logic [DATA_W-1:0] r0_data,
   output logic              r0_dvalid,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic              r1_valid,
   output logic              r1_ready,
   output logic [DATA_W-1:0] r1_data,
   output logic              r1_dvalid,
   input  logic [ADDR_W-1:0] r2_addr,
   input  logic              r2_valid,
   output logic              r2_ready,
   output logic [DATA_W-1:0] r2_data,
   output logic              r2_dvalid,
   output logic [ADDR_W-1:0] avm_m2_dout,
   output logic              avm_m2_valid,
   input  logic              avm_m2_ready,
   input  logic [DATA_W-1:0] avs_s2_dout,
   input  logic              avm_s2_valid,
   output logic              avm_s2_ready,
   output logic              busy
);

   addr_t            addr_a [N_REQ];
   logic [N_REQ-1:0] valid_v;
   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] grant;
   id_t              gnt_id;
   id_t              cand;
   logic             found;
   logic             accept;
   id_t              rr;

   id_t              head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] count;
   logic             pop;
   logic [CNT_W-1:0] count_next;

   data_t            data_q [N_REQ];
   logic [N_REQ-1:0] dvalid_q;

   assign addr_a[0] = r0_addr;
   assign addr_a[1] = r1_addr;
   assign addr_a[2] = r2_addr;
   assign valid_v   = {r2_valid, r1_valid, r0_valid};

   assign elig = valid_v & {N_REQ{~fifo_full & ~init}};

   // NOTE: every always_comb output is defaulted first so no path can infer a latch.
   always_comb begin
      grant  = '0;
      gnt_id = '0;
      found  = 1'b0;
      cand   = rr;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && elig[cand]) begin
            grant[cand] = 1'b1;
            gnt_id      = cand;
            found       = 1'b1;
         end
         cand = rr_next(cand);
      end
   end

   assign avm_m2_valid = found;
   assign avm_m2_dout  = found ? addr_a[gnt_id] : '0;
   assign accept       = found & avm_m2_ready;
   assign r0_ready     = grant[0] & avm_m2_ready;
   assign r1_ready     = grant[1] & avm_m2_ready;
   assign r2_ready     = grant[2] & avm_m2_ready;

   // A stalled grant leaves rr alone, so the same requester keeps priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        rr <= '0;
      else if (init)   rr <= '0;
      else if (accept) rr <= rr_next(gnt_id);
   end

   assign avm_s2_ready = ~fifo_empty & ~init;
   assign pop          = avm_s2_valid & avm_s2_ready;

   ai_tag_fifo u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (init),
      .push  (accept),
      .pop   (pop),
      .din   (gnt_id),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign count_next = count + CNT_W'(accept) - CNT_W'(pop);

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy     <= 1'b0;
         dvalid_q <= '0;
         for (int k = 0; k < N_REQ; k++) data_q[k] <= '0;
      end else begin
         busy     <= ~init & (count_next != '0);
         dvalid_q <= '0;
         for (int k = 0; k < N_REQ; k++) begin
            if (pop && head == id_t'(k)) begin
               dvalid_q[k] <= 1'b1;
               data_q[k]   <= avs_s2_dout;
            end
         end
      end
   end

   assign r0_data   = data_q[0];
   assign r1_data   = data_q[1];
   assign r2_data   = data_q[2];
   assign r0_dvalid = dvalid_q[0];
   assign r1_dvalid = dvalid_q[1];
   assign r2_dvalid = dvalid_q[2];

endmodule

// File: doc/ai_qram_arb.md
AI_QRAM_ARB -- requirements
Module: ai_qram_arb

Interface
REQ-001 clk  in  1  sole clock, all state on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 init  in  1  synchronous soft clear of arbitration and tag state.
REQ-004 rK_addr  in  32  read address from requester K (K = 0, 1, 2).
REQ-005 rK_valid  in  1  requester K holds a read request.
REQ-006 rK_ready  out  1  request K accepted this cycle.
REQ-007 rK_data  out  64  returned read data for requester K.
REQ-008 rK_dvalid  out  1  one-cycle strobe: rK_data is new.
REQ-009 avm_m2_dout  out  32  QRAM address command.
REQ-010 avm_m2_valid  out  1  command valid.
REQ-011 avm_m2_ready  in  1  QRAM accepts the command.
REQ-012 avs_s2_dout  in  64  QRAM read data.
REQ-013 avm_s2_valid  in  1  QRAM read data valid.
REQ-014 avm_s2_ready  out  1  arbiter accepts the read data.
REQ-015 busy  out  1  at least one read outstanding.

Function
REQ-016 Eligibility: requester K SHALL be eligible when rK_valid=1, the tag FIFO is not full, and init=0.
REQ-017 Grant: the arbiter SHALL grant, combinationally, the first eligible requester found by searching round-robin from pointer rr (rr, rr+1, rr+2 mod 3).
REQ-018 Command: avm_m2_valid SHALL equal "any grant", and avm_m2_dout SHALL equal the granted rK_addr; both SHALL be 0 when there is no grant.
REQ-019 Accept: rK_ready SHALL equal grantK & avm_m2_ready; acceptance SHALL occur on the cycle with zero added latency.
REQ-020 Rotation: on acceptance of K, rr SHALL become (K+1) mod 3; without acceptance, rr SHALL hold. A stalled grant (avm_m2_ready=0) SHALL NOT change rr.
REQ-021 Tag push: each acceptance SHALL push the 2-bit ID K into a 4-entry in-order tag FIFO.
REQ-022 Response ready: avm_s2_ready SHALL be 1 iff the FIFO is non-empty and init=0.
REQ-023 Responses arriving while the FIFO is empty SHALL be dropped, with no rK_dvalid.
REQ-024 Tag pop: on avm_s2_valid & avm_s2_ready, the head ID H SHALL pop, and on the next cycle rH_data = avs_s2_dout and rH_dvalid = 1 (latency 1).
REQ-025 Data hold: rK_data SHALL hold its value until the next response to K. rK_dvalid SHALL last exactly one cycle per response.
REQ-026 Full: with 4 entries outstanding, no grant SHALL be issued, even if a pop occurs in the same cycle.
REQ-027 Simultaneous events: push and pop in the same cycle (FIFO not full) SHALL leave the count unchanged, with both IDs kept in order.
REQ-028 Count: the count SHALL be 3 bits, 0..4; the FIFO read/write pointers SHALL be 2 bits and wrap from 3 to 0.
REQ-029 busy SHALL equal (count != 0), registered.
REQ-030 init=1: on the next edge, rr, the FIFO and the dvalid strobes SHALL clear. rK_data SHALL hold. In-flight responses SHALL then be dropped per REQ-023.

Reset
REQ-031 rst=0 SHALL asynchronously force rr=0, FIFO empty (count=0, pointers 0), rK_data=0, rK_dvalid=0, busy=0.
REQ-032 During reset, combinational outputs SHALL read as follows: avm_m2_valid follows the rK_valid inputs, rK_ready=0 unless avm_m2_ready=1, avm_s2_ready=0.
REQ-033 Reset release SHALL need no init pulse before the first grant.

Structure
REQ-034 Package ai_qram_pkg SHALL hold N_REQ=3, TAG_DEPTH=4, ID_W=2, ADDR_W=32 and DATA_W=64.
REQ-035 The tag FIFO SHALL be the sub-module ai_tag_fifo, with ports push, pop, din, dout, full, empty, count, clear (clear = init).
REQ-036 Round-robin selection and response routing SHALL stay in ai_qram_arb.

Verification
REQ-037 Single read: r1 requests 0x0000_0010 with ready=1 -> r1_ready same cycle, avm_m2_dout=0x10. Data 0xDEAD_BEEF_0123_4567 returns -> r1_data equals it one cycle later, r1_dvalid one cycle, busy 1->0.
REQ-038 Fairness: r0, r1 and r2 all request continuously with ready=1 -> grants 0,1,2,0,1,2 with no gaps until full. Each response is routed to the matching rK in that order.
REQ-039 Stall: grant to r2 with avm_m2_ready=0 for 3 cycles, while r0 raises valid -> grant stays on r2 and rr unchanged; r2 is accepted on the first ready=1.
REQ-040 Full: 4 reads accepted with no responses -> 5th request gets rK_ready=0. A response arrives with the 5th pending in the same cycle -> still no grant; the grant is issued on the following cycle.
REQ-041 init mid-flight: 2 reads outstanding, pulse init -> busy=0 and avm_s2_ready=0. Late responses produce no rK_dvalid, and the next request is granted starting from r0.
REQ-042 Async reset: assert rst=0 mid-cycle with 3 outstanding -> busy, dvalid and rK_data are 0 immediately, before the next clock edge.
